decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter ENABLE_M, default 0, SHALL enable RV32M decode when 1.
REQ-002 Parameter SKID_BUF, default 1, SHALL add a 1-entry skid buffer when 1, making in_ready a registered signal.
REQ-003 Parameter CNT_W, default 16, SHALL set the illegal-instruction counter width.
REQ-004 Ports, one per line: name, direction, width, meaning.
 - clk  in  1  single clock; all state rising-edge.
 - rst_n  in  1  reset, asynchronous assert, active-low.
 - flush  in  1  synchronous pipeline flush.
 - in_valid  in  1  fetch word valid.
 - in_ready  out  1  stage accepts word.
 - ir  in  32  instruction.
 - pc_in  in  32  instruction address.
 - out_valid  out  1  decoded bundle valid.
 - out_ready  in  1  execute accepts bundle.
 - pc_out  out  32  registered pc_in.
 - srcreg1_num, srcreg2_num, dstreg_num  out  5 each  register numbers.
 - imm  out  32  sign-extended immediate.
 - alucode  out  6  operation code.
 - aluop1_type, aluop2_type  out  2 each  operand source.
 - reg_we, is_load, is_store, is_halt, illegal  out  1 each  flags.
 - illegal_count  out  CNT_W  saturating illegal counter.

Function
REQ-005 The stage SHALL register decoded fields, giving 1-cycle latency from an accepted input to out_valid.
REQ-006 A transfer SHALL occur only when valid and ready are both high on the same edge; a held bundle SHALL stay stable while out_valid=1 and out_ready=0.
REQ-007 With SKID_BUF=0, in_ready SHALL equal (!out_valid || out_ready) && state==RUN; with SKID_BUF=1, in_ready SHALL be low only when the skid entry is occupied or state==HALTED.
REQ-008 The stage SHALL never drop, duplicate or reorder bundles.
REQ-009 alucode SHALL use this encoding: 0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4-9 BEQ/BNE/BLT/BGE/BLTU/BGEU, 10-14 LB/LH/LW/LBU/LHU, 15-17 SB/SH/SW, 18 ADD, 19 SUB, 20 SLT, 21 SLTU, 22 XOR, 23 OR, 24 AND, 25 SLL, 26 SRL, 27 SRA, 28-35 MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, 63 NOP/illegal.
REQ-010 I-type ALU ops SHALL map onto the R-type code, for example ADDI maps to 18.
REQ-011 Operand type SHALL be 0=none, 1=register, 2=immediate, 3=PC.
REQ-012 imm SHALL be sign-extended per I/S/B/U/J format, with U-type as ir[31:12]<<12; R-type imm SHALL be 0.
REQ-013 Unused register-number fields SHALL be 0.
REQ-014 reg_we SHALL be 0 when dstreg_num is 0.
REQ-015 An undefined opcode, funct3 or funct7, or opcode 0110011 with funct7=0000001 when ENABLE_M=0, SHALL set illegal=1, alucode=63, and reg_we/is_load/is_store=0.
REQ-016 ECALL (0x00000073) SHALL set is_halt=1 with alucode=63.
REQ-017 The FSM SHALL have states RUN and HALTED: RUN goes to HALTED when a halt word is accepted, and HALTED goes to RUN on flush; in HALTED, in_ready=0 while the halt bundle still drains normally.
REQ-018 illegal_count SHALL increment by 1 per illegal bundle transferred out and SHALL saturate at all-ones.
REQ-019 flush SHALL clear out_valid and the skid entry on the next edge; a simultaneous input handshake SHALL be discarded, and a simultaneous output handshake SHALL still count as transferred.

Reset
REQ-020 While rst_n=0, the stage SHALL hold out_valid=0, clear the skid entry, set state=RUN, and set illegal_count=0.
REQ-021 While rst_n=0, all data outputs SHALL be 0, with alucode=63.
REQ-022 While rst_n=0, in_ready SHALL be 0.
REQ-023 in_ready SHALL rise on the first edge after rst_n deasserts.
REQ-024 Reset mid-stall SHALL discard held bundles immediately.

Verification
REQ-025 ir=0xFFF00293 (ADDI x5,x0,-1) with out_ready=1 -> next cycle dst=5, src1=0, imm=0xFFFFFFFF, alucode=18, op1=1, op2=2, reg_we=1.
REQ-026 ir=0x022081B3 (MUL x3,x1,x2) -> ENABLE_M=0: illegal=1, alucode=63, reg_we=0, illegal_count goes 0 to 1; ENABLE_M=1: alucode=28, dst=3, src1=1, src2=2.
REQ-027 Four back-to-back words with out_ready low for cycles 2-4 -> all four emerge in order exactly once, and the bundle stays stable while stalled (both SKID_BUF values).
REQ-028 ir=0x00000073 -> is_halt=1, in_ready=0 afterward, and in_ready=1 one cycle after a flush pulse.
REQ-029 rst_n low during a stall with out_valid=1 -> out_valid=0 immediately and illegal_count=0.
REQ-030 Same-cycle flush and in_valid handshake -> out_valid=0 next cycle, with no ghost bundle.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I (+ optional RV32M) decode stage: combinational decoder feeding a registered
// valid/ready output bundle, with an optional 1-entry skid buffer and a halt FSM.
module decode_stage #(
  parameter bit ENABLE_M = 1'b0,
  parameter bit SKID_BUF = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      ir,
  input  logic [31:0]      pc_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      pc_out,
  output logic [4:0]       srcreg1_num,
  output logic [4:0]       srcreg2_num,
  output logic [4:0]       dstreg_num,
  output logic [31:0]      imm,
  output logic [5:0]       alucode,
  output logic [1:0]       aluop1_type,
  output logic [1:0]       aluop2_type,
  output logic             reg_we,
  output logic             is_load,
  output logic             is_store,
  output logic             is_halt,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_count
);

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [5:0]  alu;
    logic [1:0]  op1;
    logic [1:0]  op2;
    logic        we;
    logic        ld;
    logic        st;
    logic        halt;
    logic        ill;
  } bundle_t;

  typedef enum logic {RUN, HALTED} state_t;

  localparam bundle_t IDLE = '{pc: 32'd0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, imm: 32'd0,
                               alu: 6'd63, op1: 2'd0, op2: 2'd0, we: 1'b0, ld: 1'b0,
                               st: 1'b0, halt: 1'b0, ill: 1'b0};

  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        bad, take, alive, out_v, skid_v;
  bundle_t     dec, out_q, skid_q;
  state_t      state, state_nx;

  assign opcode = ir[6:0];
  assign f3     = ir[14:12];
  assign f7     = ir[31:25];
  assign imm_i  = {{20{ir[31]}}, ir[31:20]};
  assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u  = {ir[31:12], 12'd0};
  assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  always_comb begin
    dec    = IDLE;
    dec.pc = pc_in;
    bad    = 1'b0;
    case (opcode)
      7'b0110111: begin dec.alu = 6'd0; dec.rd = ir[11:7]; dec.imm = imm_u; dec.op2 = 2'd2; dec.we = 1'b1; end
      7'b0010111: begin dec.alu = 6'd1; dec.rd = ir[11:7]; dec.imm = imm_u; dec.op1 = 2'd3; dec.op2 = 2'd2; dec.we = 1'b1; end
      7'b1101111: begin dec.alu = 6'd2; dec.rd = ir[11:7]; dec.imm = imm_j; dec.op1 = 2'd3; dec.op2 = 2'd2; dec.we = 1'b1; end
      7'b1100111: begin
        dec.alu = 6'd3; dec.rd = ir[11:7]; dec.rs1 = ir[19:15]; dec.imm = imm_i;
        dec.op1 = 2'd1; dec.op2 = 2'd2; dec.we = 1'b1;
        bad = (f3 != 3'd0);
      end
      7'b1100011: begin
        dec.rs1 = ir[19:15]; dec.rs2 = ir[24:20]; dec.imm = imm_b; dec.op1 = 2'd1; dec.op2 = 2'd1;
        case (f3)
          3'd0: dec.alu = 6'd4;
          3'd1: dec.alu = 6'd5;
          3'd4: dec.alu = 6'd6;
          3'd5: dec.alu = 6'd7;
          3'd6: dec.alu = 6'd8;
          3'd7: dec.alu = 6'd9;
          default: bad = 1'b1;
        endcase
      end
      7'b0000011: begin
        dec.rd = ir[11:7]; dec.rs1 = ir[19:15]; dec.imm = imm_i; dec.op1 = 2'd1; dec.op2 = 2'd2;
        dec.we = 1'b1; dec.ld = 1'b1;
        case (f3)
          3'd0: dec.alu = 6'd10;
          3'd1: dec.alu = 6'd11;
          3'd2: dec.alu = 6'd12;
          3'd4: dec.alu = 6'd13;
          3'd5: dec.alu = 6'd14;
          default: bad = 1'b1;
        endcase
      end
      // Stores use the immediate as the address offset; rs2 carries the store data.
      7'b0100011: begin
        dec.rs1 = ir[19:15]; dec.rs2 = ir[24:20]; dec.imm = imm_s; dec.op1 = 2'd1; dec.op2 = 2'd2;
        dec.st = 1'b1;
        case (f3)
          3'd0: dec.alu = 6'd15;
          3'd1: dec.alu = 6'd16;
          3'd2: dec.alu = 6'd17;
          default: bad = 1'b1;
        endcase
      end
      7'b0010011: begin
        dec.rd = ir[11:7]; dec.rs1 = ir[19:15]; dec.imm = imm_i; dec.op1 = 2'd1; dec.op2 = 2'd2;
        dec.we = 1'b1;
        case (f3)
          3'd0: dec.alu = 6'd18;
          3'd1: if (f7 == 7'h00) dec.alu = 6'd25; else bad = 1'b1;
          3'd2: dec.alu = 6'd20;
          3'd3: dec.alu = 6'd21;
          3'd4: dec.alu = 6'd22;
          3'd5: if (f7 == 7'h00) dec.alu = 6'd26; else if (f7 == 7'h20) dec.alu = 6'd27; else bad = 1'b1;
          3'd6: dec.alu = 6'd23;
          default: dec.alu = 6'd24;
        endcase
      end
      7'b0110011: begin
        dec.rd = ir[11:7]; dec.rs1 = ir[19:15]; dec.rs2 = ir[24:20]; dec.op1 = 2'd1; dec.op2 = 2'd1;
        dec.we = 1'b1;
        if (f7 == 7'h00) begin
          case (f3)
            3'd0: dec.alu = 6'd18;
            3'd1: dec.alu = 6'd25;
            3'd2: dec.alu = 6'd20;
            3'd3: dec.alu = 6'd21;
            3'd4: dec.alu = 6'd22;
            3'd5: dec.alu = 6'd26;
            3'd6: dec.alu = 6'd23;
            default: dec.alu = 6'd24;
          endcase
        end else if (f7 == 7'h20 && f3 == 3'd0) dec.alu = 6'd19;
        else if (f7 == 7'h20 && f3 == 3'd5) dec.alu = 6'd27;
        else if (f7 == 7'h01 && ENABLE_M) dec.alu = 6'd28 + {3'd0, f3};
        else bad = 1'b1;
      end
      7'b1110011: begin
        if (ir == 32'h0000_0073) dec.halt = 1'b1;
        else bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      dec     = IDLE;
      dec.pc  = pc_in;
      dec.ill = 1'b1;
    end
    dec.we = dec.we && (dec.rd != 5'd0);
  end

  // alive keeps in_ready low until the first edge after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alive <= 1'b0;
    else        alive <= 1'b1;
  end

  assign in_ready = alive && (state == RUN) && (SKID_BUF ? !skid_v : (!out_v || out_ready));
  assign take     = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      RUN:     if (take && dec.halt) state_nx = HALTED;
      default: if (flush) state_nx = RUN;
    endcase
  end

  // The skid entry only fills when the output register is stalled; it always drains first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v  <= 1'b0;
      out_q  <= IDLE;
      skid_v <= 1'b0;
      skid_q <= IDLE;
    end else if (flush) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (out_v && !out_ready) begin
      if (take && SKID_BUF) begin
        skid_q <= dec;
        skid_v <= 1'b1;
      end
    end else if (skid_v) begin
      out_q  <= skid_q;
      out_v  <= 1'b1;
      skid_v <= 1'b0;
    end else if (take) begin
      out_q <= dec;
      out_v <= 1'b1;
    end else begin
      out_v <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_count <= '0;
    else if (out_v && out_ready && out_q.ill && (illegal_count != '1))
      illegal_count <= illegal_count + 1'b1;
  end

  assign out_valid   = out_v;
  assign pc_out      = out_q.pc;
  assign srcreg1_num = out_q.rs1;
  assign srcreg2_num = out_q.rs2;
  assign dstreg_num  = out_q.rd;
  assign imm         = out_q.imm;
  assign alucode     = out_q.alu;
  assign aluop1_type = out_q.op1;
  assign aluop2_type = out_q.op2;
  assign reg_we      = out_q.we;
  assign is_load     = out_q.ld;
  assign is_store    = out_q.st;
  assign is_halt     = out_q.halt;
  assign illegal     = out_q.ill;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: DUT a uses defaults (no M, skid buffer, 16-bit counter),
// DUT b uses ENABLE_M=1, SKID_BUF=0 and a 2-bit counter; sel picks which one is driven.
module tb_decode_stage;

  logic clk = 1'b0;
  logic rst_n, flush, sel;
  logic d_valid, d_ready;
  logic [31:0] d_ir, d_pc;
  int compared = 0;
  int mismatched = 0;

  logic a_in_valid, a_out_ready, a_in_ready, a_out_valid, a_we, a_ld, a_st, a_halt, a_ill;
  logic [31:0] a_pc, a_imm;
  logic [4:0] a_rs1, a_rs2, a_rd;
  logic [5:0] a_alu;
  logic [1:0] a_op1, a_op2;
  logic [15:0] a_cnt;

  logic b_in_valid, b_out_ready, b_in_ready, b_out_valid, b_we, b_ld, b_st, b_halt, b_ill;
  logic [31:0] b_pc, b_imm;
  logic [4:0] b_rs1, b_rs2, b_rd;
  logic [5:0] b_alu;
  logic [1:0] b_op1, b_op2;
  logic [1:0] b_cnt;

  logic o_in_ready, o_valid;
  logic [31:0] o_pc, o_imm;
  logic [14:0] o_regs;
  logic [5:0] o_alu;
  logic [3:0] o_ops;
  logic [4:0] o_flags;
  logic [15:0] o_cnt;

  always #5 clk = ~clk;

  assign a_in_valid  = !sel && d_valid;
  assign a_out_ready = sel || d_ready;
  assign b_in_valid  = sel && d_valid;
  assign b_out_ready = !sel || d_ready;

  assign o_in_ready = sel ? b_in_ready : a_in_ready;
  assign o_valid    = sel ? b_out_valid : a_out_valid;
  assign o_pc       = sel ? b_pc : a_pc;
  assign o_imm      = sel ? b_imm : a_imm;
  assign o_regs     = sel ? {b_rd, b_rs1, b_rs2} : {a_rd, a_rs1, a_rs2};
  assign o_alu      = sel ? b_alu : a_alu;
  assign o_ops      = sel ? {b_op1, b_op2} : {a_op1, a_op2};
  assign o_flags    = sel ? {b_we, b_ld, b_st, b_halt, b_ill} : {a_we, a_ld, a_st, a_halt, a_ill};
  assign o_cnt      = sel ? {14'd0, b_cnt} : a_cnt;

  decode_stage dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .ir(d_ir), .pc_in(d_pc), .out_valid(a_out_valid), .out_ready(a_out_ready), .pc_out(a_pc),
    .srcreg1_num(a_rs1), .srcreg2_num(a_rs2), .dstreg_num(a_rd), .imm(a_imm), .alucode(a_alu),
    .aluop1_type(a_op1), .aluop2_type(a_op2), .reg_we(a_we), .is_load(a_ld), .is_store(a_st),
    .is_halt(a_halt), .illegal(a_ill), .illegal_count(a_cnt)
  );

  decode_stage #(.ENABLE_M(1'b1), .SKID_BUF(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .ir(d_ir), .pc_in(d_pc), .out_valid(b_out_valid), .out_ready(b_out_ready), .pc_out(b_pc),
    .srcreg1_num(b_rs1), .srcreg2_num(b_rs2), .dstreg_num(b_rd), .imm(b_imm), .alucode(b_alu),
    .aluop1_type(b_op1), .aluop2_type(b_op2), .reg_we(b_we), .is_load(b_ld), .is_store(b_st),
    .is_halt(b_halt), .illegal(b_ill), .illegal_count(b_cnt)
  );

  typedef struct packed {
    logic [31:0] ir;
    logic [5:0]  alu;
    logic [14:0] regs;
    logic [31:0] imm;
    logic [3:0]  ops;
    logic [4:0]  flags;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic valid, input logic [31:0] word, input logic [31:0] pc,
                                input logic ready);
    d_valid = valid;
    d_ir    = word;
    d_pc    = pc;
    d_ready = ready;
  endtask

  // Four ADDI words tagged by their immediate; out_ready is low for cycles 2-4.
  task automatic run_stall(input string name);
    int sent, recv;
    logic held;
    logic [31:0] held_imm, held_pc;
    sent = 0;
    recv = 0;
    held = 1'b0;
    held_imm = '0;
    held_pc = '0;
    for (int c = 1; c <= 20; c++) begin
      apply_stimulus(sent < 4, 32'((sent + 1) << 20) | 32'h393, 32'h200 + 32'(4 * sent),
                     !(c >= 2 && c <= 4));
      #1;
      if (held) begin
        check_output({name, " stable imm"}, 64'(o_imm), 64'(held_imm));
        check_output({name, " stable pc"}, 64'(o_pc), 64'(held_pc));
      end
      if (o_valid && d_ready) begin
        check_output({name, " order imm"}, 64'(o_imm), 64'(recv + 1));
        check_output({name, " order pc"}, 64'(o_pc), 64'(32'h200 + 32'(4 * recv)));
        recv++;
      end
      held     = o_valid && !d_ready;
      held_imm = o_imm;
      held_pc  = o_pc;
      if (d_valid && o_in_ready) sent++;
      tick();
    end
    d_valid = 1'b0;
    check_output({name, " sent"}, 64'(sent), 64'd4);
    check_output({name, " received"}, 64'(recv), 64'd4);
    check_output({name, " drained"}, 64'(o_valid), 64'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0]  = '{32'h00812303, 6'd12, {5'd6, 5'd2, 5'd0}, 32'd8,        4'b0110, 5'b11000};
    vecs[1]  = '{32'hFE71AE23, 6'd17, {5'd0, 5'd3, 5'd7}, 32'hFFFFFFFC, 4'b0110, 5'b00100};
    vecs[2]  = '{32'hFE209CE3, 6'd5,  {5'd0, 5'd1, 5'd2}, 32'hFFFFFFF8, 4'b0101, 5'b00000};
    vecs[3]  = '{32'h12345537, 6'd0,  {5'd10, 5'd0, 5'd0}, 32'h12345000, 4'b0010, 5'b10000};
    vecs[4]  = '{32'h010000EF, 6'd2,  {5'd1, 5'd0, 5'd0}, 32'd16,       4'b1110, 5'b10000};
    vecs[5]  = '{32'h40628233, 6'd19, {5'd4, 5'd5, 5'd6}, 32'd0,        4'b0101, 5'b10000};
    vecs[6]  = '{32'h00000013, 6'd18, {5'd0, 5'd0, 5'd0}, 32'd0,        4'b0110, 5'b00000};
    vecs[7]  = '{32'h4030D093, 6'd27, {5'd1, 5'd1, 5'd0}, 32'h403,      4'b0110, 5'b10000};
    vecs[8]  = '{32'hFFFFFFFF, 6'd63, 15'd0,              32'd0,        4'b0000, 5'b00001};
    vecs[9]  = '{32'h00002063, 6'd63, 15'd0,              32'd0,        4'b0000, 5'b00001};
    vecs[10] = '{32'h00001117, 6'd1,  {5'd2, 5'd0, 5'd0}, 32'h1000,     4'b1110, 5'b10000};
    vecs[11] = '{32'h004280E7, 6'd3,  {5'd1, 5'd5, 5'd0}, 32'd4,        4'b0110, 5'b10000};

    sel = 1'b0;
    flush = 1'b0;
    rst_n = 1'b0;
    apply_stimulus(1'b0, 32'd0, 32'd0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check_output("reset out_valid", 64'(o_valid), 64'd0);
    check_output("reset in_ready", 64'(o_in_ready), 64'd0);
    check_output("reset alucode", 64'(o_alu), 64'd63);
    check_output("reset imm", 64'(o_imm), 64'd0);
    check_output("reset pc", 64'(o_pc), 64'd0);
    check_output("reset count", 64'(o_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("in_ready before first edge", 64'(o_in_ready), 64'd0);
    tick();
    check_output("in_ready after first edge", 64'(o_in_ready), 64'd1);

    apply_stimulus(1'b1, 32'hFFF00293, 32'h100, 1'b1);
    tick();
    d_valid = 1'b0;
    check_output("addi valid", 64'(o_valid), 64'd1);
    check_output("addi regs", 64'(o_regs), 64'({5'd5, 5'd0, 5'd0}));
    check_output("addi imm", 64'(o_imm), 64'hFFFFFFFF);
    check_output("addi alucode", 64'(o_alu), 64'd18);
    check_output("addi ops", 64'(o_ops), 64'b0110);
    check_output("addi flags", 64'(o_flags), 64'b10000);
    check_output("addi pc", 64'(o_pc), 64'h100);
    tick();
    check_output("addi consumed", 64'(o_valid), 64'd0);

    apply_stimulus(1'b1, 32'h022081B3, 32'h104, 1'b1);
    tick();
    d_valid = 1'b0;
    check_output("mul M=0 illegal", 64'(o_flags), 64'b00001);
    check_output("mul M=0 alucode", 64'(o_alu), 64'd63);
    check_output("mul M=0 regs", 64'(o_regs), 64'd0);
    check_output("mul M=0 count before", 64'(o_cnt), 64'd0);
    tick();
    check_output("mul M=0 count after", 64'(o_cnt), 64'd1);

    for (int i = 0; i < 12; i++) begin
      apply_stimulus(1'b1, vecs[i].ir, 32'h1000 + 32'(4 * i), 1'b1);
      tick();
      check_output($sformatf("dec%0d valid", i), 64'(o_valid), 64'd1);
      check_output($sformatf("dec%0d pc", i), 64'(o_pc), 64'(32'h1000 + 32'(4 * i)));
      check_output($sformatf("dec%0d alucode", i), 64'(o_alu), 64'(vecs[i].alu));
      check_output($sformatf("dec%0d regs", i), 64'(o_regs), 64'(vecs[i].regs));
      check_output($sformatf("dec%0d imm", i), 64'(o_imm), 64'(vecs[i].imm));
      check_output($sformatf("dec%0d ops", i), 64'(o_ops), 64'(vecs[i].ops));
      check_output($sformatf("dec%0d flags", i), 64'(o_flags), 64'(vecs[i].flags));
    end
    d_valid = 1'b0;
    tick();
    check_output("count after table", 64'(o_cnt), 64'd3);

    run_stall("stall skid");

    apply_stimulus(1'b1, 32'h00000073, 32'h300, 1'b0);
    tick();
    d_valid = 1'b0;
    check_output("halt valid", 64'(o_valid), 64'd1);
    check_output("halt flags", 64'(o_flags), 64'b00010);
    check_output("halt alucode", 64'(o_alu), 64'd63);
    check_output("halt in_ready", 64'(o_in_ready), 64'd0);
    tick();
    check_output("halt held", 64'(o_valid), 64'd1);
    d_ready = 1'b1;
    tick();
    check_output("halt drained", 64'(o_valid), 64'd0);
    check_output("halted in_ready", 64'(o_in_ready), 64'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_output("in_ready after flush", 64'(o_in_ready), 64'd1);

    apply_stimulus(1'b1, 32'hFFF00293, 32'h400, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    d_valid = 1'b0;
    check_output("flush drops input", 64'(o_valid), 64'd0);
    tick();
    check_output("flush no ghost", 64'(o_valid), 64'd0);

    apply_stimulus(1'b1, 32'hFFFFFFFF, 32'h404, 1'b0);
    tick();
    d_valid = 1'b0;
    check_output("illegal held", 64'(o_valid), 64'd1);
    check_output("count before flush xfer", 64'(o_cnt), 64'd3);
    flush = 1'b1;
    d_ready = 1'b1;
    tick();
    flush = 1'b0;
    check_output("flush xfer valid", 64'(o_valid), 64'd0);
    check_output("flush xfer counted", 64'(o_cnt), 64'd4);

    apply_stimulus(1'b1, 32'hFFFFFFFF, 32'h408, 1'b0);
    tick();
    d_valid = 1'b0;
    check_output("stall before reset", 64'(o_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("mid-stall reset valid", 64'(o_valid), 64'd0);
    check_output("mid-stall reset count", 64'(o_cnt), 64'd0);
    check_output("mid-stall reset in_ready", 64'(o_in_ready), 64'd0);
    check_output("mid-stall reset alucode", 64'(o_alu), 64'd63);
    @(negedge clk);
    rst_n = 1'b1;
    d_ready = 1'b1;
    tick();
    check_output("in_ready after re-reset", 64'(o_in_ready), 64'd1);

    sel = 1'b1;
    apply_stimulus(1'b1, 32'h022081B3, 32'h500, 1'b0);
    tick();
    d_valid = 1'b0;
    check_output("mul M=1 alucode", 64'(o_alu), 64'd28);
    check_output("mul M=1 regs", 64'(o_regs), 64'({5'd3, 5'd1, 5'd2}));
    check_output("mul M=1 flags", 64'(o_flags), 64'b10000);
    check_output("noskid stalled in_ready", 64'(o_in_ready), 64'd0);
    d_ready = 1'b1;
    #1;
    check_output("noskid in_ready follows out_ready", 64'(o_in_ready), 64'd1);
    tick();
    check_output("mul M=1 consumed", 64'(o_valid), 64'd0);

    run_stall("stall noskid");

    apply_stimulus(1'b1, 32'hFFFFFFFF, 32'h600, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_output($sformatf("sat step%0d", k), 64'(o_cnt), 64'(k));
    end
    d_valid = 1'b0;
    tick();
    check_output("sat hold", 64'(o_cnt), 64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
